raytracing_scheduler: RTL and testbench
=======================================

RAYTRACING_SCHEDULER -- requirements
Module: raytracing_scheduler

Interface
REQ-001 Parameters SHALL be: N_WORKERS, default 10, number of Raytracing workers; SUBDIV, default 64, pixels per worker per line; V_RES, default 480, lines per frame; TIMEOUT_CYCLES, default 1048576, watchdog limit. H_RES is N_WORKERS*SUBDIV (640).
REQ-002 clk  in  1  system clock; the block has one clock domain.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  frame start pulse, sampled only in IDLE.
REQ-005 sched_busy  out  1  high from frame accept until frame_done.
REQ-006 frame_done  out  1  one-cycle pulse after the last pixel of the frame.
REQ-007 err  out  1  sticky watchdog flag.
REQ-008 worker_activate  out  1  shared activate to all workers.
REQ-009 worker_pixel_y  out  10 signed  current line y coordinate.
REQ-010 worker_pixel_y_sqrd  out  16  square of worker_pixel_y.
REQ-011 worker_pixel_start_x  out  N_WORKERS x 12 signed  per-worker start x; entry w is w-320.
REQ-012 worker_busy  in  N_WORKERS  per-worker busy.
REQ-013 worker_buffer  in  N_WORKERS x SUBDIV x 12  per-worker Color buffers.
REQ-014 px_valid / px_ready  out / in  1 / 1  pixel output handshake.
REQ-015 px_addr  out  19  linear framebuffer address.
REQ-016 px_color  out  12  Color.

Function
REQ-017 The FSM SHALL have the states IDLE, LAUNCH, WAIT, DRAIN and RELEASE.
REQ-018 IDLE with start=1 SHALL do the following on the next cycle: row:=0, addr:=0, err:=0, sched_busy:=1, state:=LAUNCH. start outside IDLE SHALL be ignored.
REQ-019 LAUNCH SHALL do the following: worker_activate:=1, clear all started flags and the watchdog counter, then go to WAIT.
REQ-020 worker_pixel_y SHALL equal 240-row. worker_pixel_y_sqrd SHALL be its exact square, with a maximum of 57600. Both SHALL be stable from LAUNCH through RELEASE.
REQ-021 WAIT SHALL do the following: started[w] |= worker_busy[w]. Go to DRAIN on the first cycle where all started flags are 1 and worker_busy is all zero.
REQ-022 DRAIN SHALL drive the following: px_valid=1, px_addr=addr, px_color=worker_buffer[x mod N_WORKERS][x div N_WORKERS], with x counting 0..H_RES-1. The x counter SHALL be kept as a worker counter plus a slot counter, with no divider.
REQ-023 On px_valid and px_ready, addr and x SHALL advance. The accept at x=H_RES-1 SHALL drop px_valid and go to RELEASE.
REQ-024 While px_valid=1 and px_ready=0, px_addr and px_color SHALL be held stable.
REQ-025 RELEASE SHALL hold worker_activate=0 for exactly one cycle, which resets the workers.
  - row=V_RES-1: pulse frame_done, sched_busy:=0, go to IDLE.
  - otherwise: row:=row+1, go to LAUNCH.
REQ-026 addr SHALL run continuously across lines. The final pixel SHALL use addr 307199.
REQ-027 Minimum line time SHALL be LAUNCH(1) + WAIT + H_RES + RELEASE(1) cycles with px_ready held at 1.

Reset
REQ-028 rst=1 SHALL force the following on the next edge, regardless of state, including mid-DRAIN:
  - state:=IDLE
  - outputs zero: worker_activate, px_valid, sched_busy, frame_done, err
  - counters zero: row, addr, x, started, watchdog
  The workers are released because activate is low.

Configuration
REQ-029 With macro SCHED_TIMEOUT_EN defined, the watchdog counter SHALL increment each WAIT cycle. When it reaches TIMEOUT_CYCLES:
  - err:=1
  - go to DRAIN with px_color forced to `BACKGROUND_COLOR for the whole line
  - continue normally afterwards.
  err SHALL clear only on accepted start or rst.
REQ-030 Without SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely. err SHALL be tied to 0 and no counter logic SHALL be synthesized.

Verification
REQ-031 Nominal line: 10 mock workers with busy high for 100 cycles, buffer[w][k]=w*64+k, px_ready=1 -> 640 pixels with px_addr 0..639 and px_color at x=23 equal to 3*64+2=194. Line time SHALL be 100+ plus 642 overhead.
REQ-032 Backpressure: px_ready toggled 1/0 every cycle -> no duplicated or dropped addresses, and px_color held stable while stalled.
REQ-033 Full frame with V_RES=4 -> addr ends at 2559. frame_done SHALL pulse exactly once. worker_pixel_y SHALL go 240, 239, 238, 237. worker_activate SHALL go low exactly once between lines.
REQ-034 Late worker: worker 7 raises busy 5 cycles after the others and drops it last -> DRAIN SHALL start only after worker 7 drops busy.
REQ-035 Reset mid-DRAIN at x=300: rst for 1 cycle -> all outputs 0 and state IDLE. A subsequent start SHALL restart at addr 0.
REQ-036 SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=50 and worker 0 stuck busy -> err=1 after 50 WAIT cycles and 640 `BACKGROUND_COLOR pixels. The next start SHALL clear err.

Source files
------------

// File: rtl/raytracing_scheduler.sv
// Scanline scheduler for a pool of raytracing workers: launch, wait, drain buffers, release.
// Optional line watchdog enabled by defining SCHED_TIMEOUT_EN.
`ifndef BACKGROUND_COLOR
`define BACKGROUND_COLOR 12'h000
`endif

module raytracing_scheduler #(
  parameter int N_WORKERS      = 10,
  parameter int SUBDIV         = 64,
  parameter int V_RES          = 480,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  sched_busy,
  output logic                                  frame_done,
  output logic                                  err,
  output logic                                  worker_activate,
  output logic signed [9:0]                     worker_pixel_y,
  output logic [15:0]                           worker_pixel_y_sqrd,
  output logic [N_WORKERS-1:0][11:0]            worker_pixel_start_x,
  input  logic [N_WORKERS-1:0]                  worker_busy,
  input  logic [N_WORKERS-1:0][SUBDIV-1:0][11:0] worker_buffer,
  output logic                                  px_valid,
  input  logic                                  px_ready,
  output logic [18:0]                           px_addr,
  output logic [11:0]                           px_color
);
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int WK_W  = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
  localparam int SL_W  = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, RELEASE} state_t;

  state_t               state_reg, state_next;
  logic [ROW_W-1:0]     row_reg, row_next;
  logic [18:0]          addr_reg, addr_next;
  logic [WK_W-1:0]      wk_reg, wk_next;
  logic [SL_W-1:0]      slot_reg, slot_next;
  logic [N_WORKERS-1:0] started_reg, started_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 activate_reg, activate_next;
  logic                 all_done;
  logic                 timeout;
  logic                 bg_line;
  logic [9:0]           y_abs;

  assign all_done = (&started_reg) && !(|worker_busy);

  // Worker w owns pixels w, w+N, w+2N, ... so its first x sits w pixels right of -320.
  generate
    for (genvar gi = 0; gi < N_WORKERS; gi++) begin : g_start_x
      assign worker_pixel_start_x[gi] = 12'(gi) - 12'd320;
    end
  endgenerate

  assign worker_pixel_y      = 10'sd240 - $signed({{(10-ROW_W){1'b0}}, row_reg});
  assign y_abs               = worker_pixel_y[9] ? 10'(-worker_pixel_y) : worker_pixel_y;
  assign worker_pixel_y_sqrd = {6'd0, y_abs} * {6'd0, y_abs};

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_reg;
  logic            err_reg;
  logic            bg_reg;

  assign timeout = (state_reg == WAIT) && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_reg  <= '0;
      err_reg <= 1'b0;
      bg_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE:   if (start) err_reg <= 1'b0;
        LAUNCH: begin
          wd_reg <= '0;
          bg_reg <= 1'b0;
        end
        WAIT: begin
          wd_reg <= wd_reg + WD_W'(1);
          // A line that completes on the expiry cycle is still drained normally.
          if (timeout && !all_done) begin
            err_reg <= 1'b1;
            bg_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err     = err_reg;
  assign bg_line = bg_reg;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
  assign bg_line = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    row_next      = row_reg;
    addr_next     = addr_reg;
    wk_next       = wk_reg;
    slot_next     = slot_reg;
    started_next  = started_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          row_next   = '0;
          addr_next  = '0;
          busy_next  = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        started_next = '0;
        wk_next      = '0;
        slot_next    = '0;
        state_next   = WAIT;
      end
      WAIT: begin
        started_next = started_reg | worker_busy;
        if (all_done || timeout) state_next = DRAIN;
      end
      DRAIN: begin
        if (px_ready) begin
          addr_next = addr_reg + 19'd1;
          // x = slot*N + worker, walked without any division.
          if (wk_reg == WK_W'(N_WORKERS - 1)) begin
            wk_next = '0;
            if (slot_reg == SL_W'(SUBDIV - 1)) begin
              slot_next  = '0;
              state_next = RELEASE;
            end else begin
              slot_next = slot_reg + SL_W'(1);
            end
          end else begin
            wk_next = wk_reg + WK_W'(1);
          end
        end
      end
      RELEASE: begin
        if (row_reg == ROW_W'(V_RES - 1)) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          row_next   = row_reg + ROW_W'(1);
          state_next = LAUNCH;
        end
      end
      default: state_next = IDLE;
    endcase
    activate_next = (state_next == LAUNCH) || (state_next == WAIT) || (state_next == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      row_reg      <= '0;
      addr_reg     <= '0;
      wk_reg       <= '0;
      slot_reg     <= '0;
      started_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      activate_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_reg      <= row_next;
      addr_reg     <= addr_next;
      wk_reg       <= wk_next;
      slot_reg     <= slot_next;
      started_reg  <= started_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      activate_reg <= activate_next;
    end
  end

  assign sched_busy      = busy_reg;
  assign frame_done      = done_reg;
  assign worker_activate = activate_reg;
  assign px_valid        = (state_reg == DRAIN);
  assign px_addr         = addr_reg;
  assign px_color        = bg_line ? 12'(`BACKGROUND_COLOR) : worker_buffer[wk_reg][slot_reg];

endmodule

// File: tb/tb_raytracing_scheduler.sv
// Directed bench for raytracing_scheduler: mock workers, nominal/backpressure/late-worker lines,
// full 4-line frame, reset mid-drain, and the watchdog path when SCHED_TIMEOUT_EN is defined.
`ifndef BACKGROUND_COLOR
`define BACKGROUND_COLOR 12'h000
`endif

module tb_raytracing_scheduler;
  localparam int NW = 10;
  localparam int SD = 64;
  localparam int VR = 4;
  localparam int TO = 50;
  localparam int HR = NW * SD;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic                       sched_busy;
  logic                       frame_done;
  logic                       err;
  logic                       worker_activate;
  logic signed [9:0]          worker_pixel_y;
  logic [15:0]                worker_pixel_y_sqrd;
  logic [NW-1:0][11:0]        worker_pixel_start_x;
  logic [NW-1:0]              worker_busy;
  logic [NW-1:0][SD-1:0][11:0] worker_buffer;
  logic                       px_valid;
  logic                       px_ready;
  logic [18:0]                px_addr;
  logic [11:0]                px_color;

  int total = 0;
  int bad   = 0;
  int dly[NW];
  int len[NW];
  int age = 0;
  int fd_cnt = 0;
  int act_low_cnt = 0;

  raytracing_scheduler #(
    .N_WORKERS(NW), .SUBDIV(SD), .V_RES(VR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .sched_busy(sched_busy), .frame_done(frame_done), .err(err),
    .worker_activate(worker_activate),
    .worker_pixel_y(worker_pixel_y), .worker_pixel_y_sqrd(worker_pixel_y_sqrd),
    .worker_pixel_start_x(worker_pixel_start_x),
    .worker_busy(worker_busy), .worker_buffer(worker_buffer),
    .px_valid(px_valid), .px_ready(px_ready), .px_addr(px_addr), .px_color(px_color)
  );

  always #5 clk = ~clk;

  // Mock workers: busy for len cycles starting dly cycles after activate rises.
  always @(posedge clk) begin
    if (!worker_activate) age <= 0;
    else if (age < 1000000) age <= age + 1;
  end

  always_comb begin
    worker_busy = '0;
    for (int w = 0; w < NW; w++)
      worker_busy[w] = (age >= dly[w]) && (age < dly[w] + len[w]);
  end

  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (sched_busy && !worker_activate) act_low_cnt <= act_low_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_color(input int x, input bit bg);
    if (bg) return 12'(`BACKGROUND_COLOR);
    return 12'((x % NW) * SD + x / NW);
  endfunction

  // Entered at the LAUNCH-cycle negedge; returns at the RELEASE-cycle negedge.
  task automatic run_line(input int row, input bit toggle, input int base, input bit bg,
                          input int exp_pre);
    int pre, x, guard, nbad, bx, last;
    logic [18:0] ba;
    logic [11:0] bc;
    logic [11:0] c23;
    pre = 0; guard = 0; nbad = 0; bx = 0; ba = '0; bc = '0; c23 = '0; last = -1;
    px_ready = 1'b1;
    while (!px_valid && guard < 3000) begin
      if (worker_activate) pre++;
      guard++;
      @(negedge clk);
    end
    chk("drain_reached", 32'(px_valid), 32'd1);
    if (!px_valid) return;
    chk("pre_drain_cycles", pre, exp_pre);
    chk("pixel_y", worker_pixel_y, 240 - row);
    chk("pixel_y_sqrd", worker_pixel_y_sqrd, (240 - row) * (240 - row));
    x = 0; guard = 0;
    while (x < HR && guard < 4000) begin
      if (!px_valid || px_addr !== 19'(base + x) || px_color !== exp_color(x, bg)) begin
        if (nbad == 0) begin bx = x; ba = px_addr; bc = px_color; end
        nbad++;
      end
      if (x == 23) c23 = px_color;
      px_ready = toggle ? ((guard % 2) == 0) : 1'b1;
      if (px_valid && px_ready) begin
        last = int'(px_addr);
        x++;
      end
      guard++;
      @(negedge clk);
    end
    total++;
    assert (nbad === 0) else begin
      bad++;
      $error("FAIL line%0d_pixels: %0d bad, first x=%0d addr=%0d color=%0d expected addr=%0d color=%0d",
             row, nbad, bx, ba, bc, base + bx, exp_color(bx, bg));
    end
    chk("pixels_drained", x, HR);
    chk("drain_cycles", guard, toggle ? 2 * HR - 1 : HR);
    chk("color_x23", c23, bg ? 32'(`BACKGROUND_COLOR) : 32'd194);
    chk("last_addr", last, base + HR - 1);
    chk("release_valid_low", 32'(px_valid), 32'd0);
    chk("release_activate_low", 32'(worker_activate), 32'd0);
    px_ready = 1'b1;
    $display("line row=%0d base=%0d toggle=%0d bg=%0d pre=%0d drain=%0d", row, base, toggle, bg, pre, guard);
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(sched_busy), 32'd1);
    chk("err_after_start", 32'(err), 32'd0);
  endtask

  initial begin
    int fd0, al0;
    for (int w = 0; w < NW; w++) begin
      dly[w] = 1;
      len[w] = 100;
      for (int k = 0; k < SD; k++) worker_buffer[w][k] = 12'(w * SD + k);
    end
    rst = 1'b1; start = 1'b0; px_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(sched_busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_activate", 32'(worker_activate), 32'd0);
    chk("rst_valid", 32'(px_valid), 32'd0);
    chk("start_x0", 32'(worker_pixel_start_x[0]), 32'h0EC0);
    chk("start_x9", 32'(worker_pixel_start_x[9]), 32'h0EC9);
    repeat (3) @(negedge clk);
    chk("idle_stays_idle", 32'(sched_busy), 32'd0);

    // Full frame: nominal, backpressure with start held high, late worker 7, nominal.
    fd0 = fd_cnt; al0 = act_low_cnt;
    start_frame();
    run_line(0, 1'b0, 0, 1'b0, 102);
    start = 1'b1;
    @(negedge clk);
    run_line(1, 1'b1, HR, 1'b0, 102);
    start = 1'b0;
    dly[7] = 6;
    @(negedge clk);
    run_line(2, 1'b0, 2 * HR, 1'b0, 107);
    dly[7] = 1;
    @(negedge clk);
    run_line(3, 1'b0, 3 * HR, 1'b0, 102);
    chk("busy_in_last_release", 32'(sched_busy), 32'd1);
    @(negedge clk);
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("busy_cleared", 32'(sched_busy), 32'd0);
    @(negedge clk);
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    chk("frame_done_count", fd_cnt - fd0, 1);
    chk("activate_low_count", act_low_cnt - al0, VR);

    // Reset in the middle of a drain, then restart from address 0.
    start_frame();
    begin
      int g;
      g = 0;
      while (!px_valid && g < 3000) begin g++; @(negedge clk); end
    end
    repeat (300) @(negedge clk);
    chk("mid_drain_addr", px_addr, 300);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(px_valid), 32'd0);
    chk("midrst_busy", 32'(sched_busy), 32'd0);
    chk("midrst_activate", 32'(worker_activate), 32'd0);
    chk("midrst_done", 32'(frame_done), 32'd0);
    chk("midrst_addr", px_addr, 0);
    repeat (3) @(negedge clk);
    chk("midrst_idle", 32'(px_valid | sched_busy | worker_activate), 32'd0);
    start_frame();
    run_line(0, 1'b0, 0, 1'b0, 102);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

`ifdef SCHED_TIMEOUT_EN
    // Worker 0 never finishes line 0; watchdog drains a background line.
    len[0] = 1000000;
    start_frame();
    run_line(0, 1'b0, 0, 1'b1, TO + 1);
    chk("timeout_err", 32'(err), 32'd1);
    len[0] = 100;
    for (int r = 1; r < VR; r++) begin
      @(negedge clk);
      run_line(r, 1'b0, r * HR, 1'b0, 102);
    end
    chk("err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    start_frame();
    chk("err_cleared_by_start", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
